// File: rtl/rr_grant_sched_if.sv
// Request/grant bundle between N requesters and the round-robin grant scheduler.
// Handshake: req[i] is a level held high by requester i for its whole tenure;
// gnt[i] is the scheduler's one-hot acknowledgement. A tenure is active on
// every cycle where req[i] && gnt[i]. The requester ends it by dropping req[i],
// and the scheduler never raises gnt[i] unless req[i] was high on that edge.
interface rr_grant_sched_if #(
  parameter int N = 4
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            tmo;

  // Requester side drives req and observes the grant.
  modport master (output req, input gnt, input gnt_id, input busy, input tmo);
  // Scheduler side observes req and drives the grant.
  modport slave  (input req, output gnt, output gnt_id, output busy, output tmo);
endinterface

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler with non-preemptive tenures.
// FSM IDLE -> GRANT -> GAP -> IDLE. The winner is the first requesting index
// searching upward from last_id+1 with wrap-around; last_id resets to N-1 so
// requester 0 has top priority after reset. The first edge after reset
// release never grants (an internal run flag arms the arbiter).
// Optional macro ARB_TIMEOUT_EN adds an 8-bit hold counter that forces a
// release, with a one-cycle tmo pulse, after MAX_HOLD granted cycles.
module rr_grant_sched #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_grant_sched_if.slave    bus,
  output logic [1:0]         dbg_state_o
);

  localparam int ID_W = $clog2(N);
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic [ID_W-1:0] last_id_q;
  logic            busy_q;
  logic            run_q;

  logic            win_found_d;
  logic [ID_W-1:0] win_id_d;
  logic [ID_W-1:0] cand;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]      hold_q;
  logic            tmo_q;
`endif

  // Rotating priority search: first set req bit above last_id, wrapping.
  always_comb begin
    win_found_d = 1'b0;
    win_id_d    = last_id_q;
    cand        = last_id_q;
    for (int i = 1; i <= N; i++) begin
      cand = ID_W'((int'(last_id_q) + i) % N);
      if (!win_found_d && bus.req[cand]) begin
        win_found_d = 1'b1;
        win_id_d    = cand;
      end
    end
  end

  // Grant FSM with registered gnt/busy/last_id (and hold counter/tmo).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_id_q <= ID_W'(N - 1);
      busy_q    <= 1'b0;
      run_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      tmo_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (run_q && win_found_d) begin
            state_q   <= GRANT;
            gnt_q     <= {{(N-1){1'b0}}, 1'b1} << win_id_d;
            last_id_q <= win_id_d;
            busy_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
`endif
          end
        end
        GRANT: begin
          if (!bus.req[last_id_q]) begin
            // Owner released: a normal release wins over an expiring timeout.
            state_q <= GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_q == HOLD_LIMIT) begin
            state_q <= GAP;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = last_id_q;
  assign bus.busy    = busy_q;
  assign dbg_state_o = state_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.tmo = tmo_q;
`else
  // Tenure is unbounded; the hold limit only matters with the timeout feature.
  logic unused_hold_limit;
  assign unused_hold_limit = ^HOLD_LIMIT;
  assign bus.tmo           = 1'b0;
`endif

endmodule
